// File: rtl/div_iter_16.sv
// Iterative unsigned divider: restoring shift-subtract, one quotient bit per clock.
// A start accepted at edge N yields a held quotient/remainder with o_valid after edge N+16.
module div_iter_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dividend_reg, divisor_reg, rem_reg, quo_reg;
  logic [WIDTH:0]   trial;
  logic             take, accept, last;
  logic [WIDTH-1:0] rem_next, quo_next;

  assign accept = i_start && (state != RUN);
  assign last   = (state == RUN) && (cnt == '0);

  // One reused stage: 17-bit trial so divisors >= 0x8000 compare correctly.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    trial    = {rem_reg, dividend_reg[cnt]};
    take     = (trial >= {1'b0, divisor_reg});
    rem_next = take ? (trial[WIDTH-1:0] - divisor_reg) : trial[WIDTH-1:0];
    quo_next = quo_reg;
    quo_next[cnt] = take;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (cnt == '0) state_next = DONE;
      DONE:    if (accept) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      dividend_reg <= '0;
      divisor_reg  <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      o_quotient   <= '0;
      o_remainder  <= '0;
    end else if (accept) begin
      cnt          <= CW'(WIDTH - 1);
      dividend_reg <= i_dividend;
      divisor_reg  <= i_divisor;
      rem_reg      <= '0;
      quo_reg      <= '0;
    end else if (state == RUN) begin
      cnt     <= cnt - CW'(1);
      rem_reg <= rem_next;
      quo_reg <= quo_next;
      if (last) begin
        // A zero divisor would otherwise yield all-ones; force the defined 0/0 result.
        o_quotient  <= (divisor_reg == '0) ? '0 : quo_next;
        o_remainder <= (divisor_reg == '0) ? '0 : rem_next;
      end
    end
  end

  assign o_busy  = (state == RUN);
  assign o_valid = (state == DONE);

endmodule

// File: tb/tb_div_iter_16.sv
// Directed and randomized bench for div_iter_16: results, 16-cycle latency,
// ignored start while busy, back-to-back start and asynchronous abort.
module tb_div_iter_16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy, valid;
  logic [15:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  div_iter_16 dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (start),
    .i_dividend  (dividend),
    .i_divisor   (divisor),
    .o_busy      (busy),
    .o_valid     (valid),
    .o_quotient  (quotient),
    .o_remainder (remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a start for one edge, then scramble the operands after acceptance.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = 16'($urandom);
    divisor = 16'($urandom);
  endtask

  // Called #1 after an edge that is lat0 edges past the accepting edge.
  task automatic wait_done(input int lat0, input logic [15:0] eq, input logic [15:0] er,
                           input string tag);
    int lat = lat0;
    logic busy_ok = 1'b1;
    while (!valid && lat < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd16);
    check({tag, "_busy_run"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_quotient"}, {16'd0, quotient}, {16'd0, eq});
    check({tag, "_remainder"}, {16'd0, remainder}, {16'd0, er});
  endtask

  task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er, input string tag);
    start_op(a, b);
    check({tag, "_valid_drop"}, {31'd0, valid}, 32'd0);
    wait_done(0, eq, er, tag);
  endtask

  initial begin
    logic [15:0] ra, rb, rq, rr;

    #3 rst = 1'b1;
    #10;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_quotient", {16'd0, quotient}, 32'd0);
    check("reset_remainder", {16'd0, remainder}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div(16'd100, 16'd7, 16'd14, 16'd2, "d100_7");
    run_div(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, "ffff_1");
    run_div(16'hFFFF, 16'hFFFE, 16'h0001, 16'h0001, "ffff_fffe");
    run_div(16'h8000, 16'h8001, 16'h0000, 16'h8000, "8000_8001");
    run_div(16'd5, 16'd9, 16'd0, 16'd5, "d5_9");
    run_div(16'h1234, 16'h0000, 16'h0000, 16'h0000, "div_zero");

    // Outputs stay put while held in DONE.
    repeat (3) @(posedge clk);
    #1;
    check("hold_valid", {31'd0, valid}, 32'd1);
    check("hold_quotient", {16'd0, quotient}, 32'd0);

    // Second start during RUN must be ignored.
    start_op(16'd1000, 16'd3);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    start = 1'b1;
    dividend = 16'd50;
    divisor = 16'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(5, 16'd333, 16'd1, "ignored_start");

    // Start in the first valid cycle.
    run_div(16'd50, 16'd5, 16'd10, 16'd0, "back_to_back");

    // Asynchronous abort mid-operation.
    start_op(16'd40000, 16'd123);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    #1 rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_valid", {31'd0, valid}, 32'd0);
    check("abort_quotient", {16'd0, quotient}, 32'd0);
    check("abort_remainder", {16'd0, remainder}, 32'd0);
    #4 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_result", {31'd0, valid}, 32'd0);
    run_div(16'd40000, 16'd123, 16'd325, 16'd25, "after_abort");

    // Randomized sweep against a behavioural reference.
    for (int n = 0; n < 2000; n++) begin
      ra = 16'($urandom);
      case (n % 8)
        0:       rb = 16'd0;
        1:       rb = 16'h8000 | 16'($urandom);
        2:       rb = 16'($urandom_range(1, 15));
        default: rb = 16'($urandom);
      endcase
      rq = (rb == 16'd0) ? 16'd0 : ra / rb;
      rr = (rb == 16'd0) ? 16'd0 : ra % rb;
      run_div(ra, rb, rq, rr, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
